stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLR_CYCLES, default 4: number of cycles the clear code is driven after reset or a clear request.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port btn_start  input  1  raw, asynchronous start/stop button, active-high.
REQ-005 Port btn_lap  input  1  raw, asynchronous lap/clear button, active-high.
REQ-006 Port count  input  24  live count from the stopwatch datapath.
REQ-007 Port control  output  2  command to the stopwatch datapath: 0 = clear, 1 = run, 2 = hold; 3 is never driven.
REQ-008 Port display_count  output  24  value for the display: lap_reg while frozen, otherwise count.
REQ-009 Port running  output  1  high in RUN and LAP.
REQ-010 Port frozen  output  1  high in LAP only.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer plus a previous-value register; one rising edge SHALL produce exactly one 1-cycle pulse (start_p, lap_p).
REQ-012 Holding a button high SHALL produce no further pulses until it goes low and rises again.
REQ-013 The FSM SHALL have the states CLEAR, IDLE, RUN, LAP and PAUSE; control, running and frozen SHALL be decoded from the state register only.
REQ-014 CLEAR: control=0; the down-counter is loaded with CLR_CYCLES-1 on entry; when it reaches 0 the FSM SHALL go to IDLE; all pulses SHALL be ignored.
REQ-015 IDLE: control=2; start_p -> RUN; lap_p ignored.
REQ-016 RUN: control=1; start_p -> PAUSE; lap_p -> LAP, and lap_reg <= count in the same edge.
REQ-017 LAP: control=1, display frozen at lap_reg; lap_p -> RUN with no new capture; start_p -> PAUSE and the freeze is released.
REQ-018 PAUSE: control=2; start_p -> RUN; lap_p -> CLEAR.
REQ-019 If start_p and lap_p arrive in the same cycle, start_p SHALL win and lap_p SHALL be dropped.
REQ-020 Latency: the button is first sampled high at edge N; control SHALL change after edge N+3; no other path SHALL add a cycle.
REQ-021 display_count SHALL be a combinational mux, selected by frozen; lap_reg is 24 bits and holds its value outside LAP-entry captures.
REQ-022 The clear counter width SHALL be $clog2(CLR_CYCLES)+1; CLR_CYCLES>=1.

Reset
REQ-023 When rst_n=0 at a clock edge: state=CLEAR, clear counter=CLR_CYCLES-1, lap_reg=0, synchronizer and previous-value registers=0.
REQ-024 Output values during and immediately after reset: control=0, running=0, frozen=0, display_count=count.
REQ-025 Reset asserted mid-operation (any state, including LAP) SHALL override every pulse in that cycle.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the control encodings CTRL_CLR=2'd0, CTRL_RUN=2'd1 and CTRL_HOLD=2'd2, and the FSM state enum.
REQ-027 Sub-module btn_edge (synchronizer, edge detect, clk/rst_n) SHALL be instantiated twice; the FSM, lap register and mux stay in stopwatch_ctrl.

Verification
REQ-028 Reset release, no buttons -> control=0 for exactly 4 cycles, then 2 (IDLE), running=0.
REQ-029 From IDLE, btn_start high at edge N -> control=1 after edge N+3; holding it high 50 cycles -> no PAUSE.
REQ-030 In RUN with count=24'h000123, press lap -> frozen=1 and display_count=24'h000123 while count advances; second lap press -> display_count tracks count, frozen=0.
REQ-031 In RUN, start and lap rise on the same edge -> PAUSE (control=2), lap_reg unchanged.
REQ-032 In PAUSE, press lap -> control=0 for 4 cycles, then 2; pulses during CLEAR are ignored.
REQ-033 In LAP, drive rst_n=0 for 1 cycle -> control=0, frozen=0 and lap_reg=0 on the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: datapath command encodings and controller state type shared by the stopwatch blocks.
package stopwatch_pkg;
  localparam logic [1:0] CTRL_CLR  = 2'd0;
  localparam logic [1:0] CTRL_RUN  = 2'd1;
  localparam logic [1:0] CTRL_HOLD = 2'd2;
  typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_RUN, ST_LAP, ST_PAUSE} state_e;
  function automatic logic [1:0] ctrl_of(state_e s);
    return (s == ST_CLEAR) ? CTRL_CLR : (s == ST_RUN || s == ST_LAP) ? CTRL_RUN : CTRL_HOLD;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: synchronizes a raw button and emits one registered single-cycle pulse per rising edge.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  logic sync1_q, sync2_q, prev_q, pulse_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/lap/pause/clear controller for a stopwatch datapath with lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic [23:0] count,
  output logic [1:0]  control,
  output logic [23:0] display_count,
  output logic        running,
  output logic        frozen
);
  localparam int CW = $clog2(CLR_CYCLES) + 1;
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [23:0] lap_q, lap_d;
  logic start_p, lap_p;
  btn_edge u_start (.clk(clk), .rst_n(rst_n), .btn_i(btn_start), .pulse_o(start_p));
  btn_edge u_lap   (.clk(clk), .rst_n(rst_n), .btn_i(btn_lap),   .pulse_o(lap_p));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_q   <= CLR_LOAD;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end
  // The clear counter sits preloaded outside CLEAR, so every entry starts a full clear window.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = (state_q == ST_CLEAR && clr_q != '0) ? clr_q - CW'(1) : CLR_LOAD;
    case (state_q)
      ST_CLEAR: state_d = (clr_q == '0) ? ST_IDLE : ST_CLEAR;
      ST_IDLE:  state_d = start_p ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        state_d = start_p ? ST_PAUSE : lap_p ? ST_LAP : ST_RUN;
        lap_d   = (!start_p && lap_p) ? count : lap_q;
      end
      ST_LAP:   state_d = start_p ? ST_PAUSE : lap_p ? ST_RUN : ST_LAP;
      ST_PAUSE: state_d = start_p ? ST_RUN : lap_p ? ST_CLEAR : ST_PAUSE;
      default:  state_d = ST_CLEAR;
    endcase
  end
  assign control       = ctrl_of(state_q);
  assign running       = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign frozen        = (state_q == ST_LAP);
  assign display_count = frozen ? lap_q : count;
endmodule
